// File: rtl/mult_pkg.sv
// Shared types and widths for the dot-product sequencer and its multiply engine.
package mult_pkg;

  localparam int OPND_W    = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    ACCUM,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mult_dot_seq_if.sv
// Operand stream, multiplier side-channel and result handshake of mult_dot_seq.
interface mult_dot_seq_if #(
  parameter int ACC_W = mult_pkg::ACC_W_DEF,
  parameter int CNT_W = mult_pkg::CNT_W_DEF
);
  import mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic              in_last;

  logic              mult_start;
  logic [OPND_W-1:0] mult_a;
  logic [OPND_W-1:0] mult_b;
  logic              mult_ready;
  logic [PROD_W-1:0] mult_r;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // The sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_last, mult_ready, mult_r, out_ready,
    output in_ready, mult_start, mult_a, mult_b, out_valid, out_sum, out_count, out_ovf
  );

  // The environment: operand source, multiply engine and result consumer.
  modport master (
    output in_valid, in_a, in_b, in_last, mult_ready, mult_r, out_ready,
    input  in_ready, mult_start, mult_a, mult_b, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/asmd_mult.sv
// 8x8 shift-and-add sequential multiplier; zero operands take a one-cycle short path.
module asmd_mult
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  output logic              o_ready,
  output logic [PROD_W-1:0] o_r
);

  typedef enum logic [1:0] {
    M_IDLE,
    M_SHORT,
    M_RUN
  } mstate_t;

  mstate_t           r_st;
  logic [3:0]        r_n;
  logic [PROD_W-1:0] r_mcand;
  logic [PROD_W-1:0] r_p;
  logic [OPND_W-1:0] r_mplier;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= M_IDLE;
      r_n  <= '0;
    end else begin
      case (r_st)
        M_IDLE: begin
          if (i_start) begin
            r_st <= ((~|i_a) || (~|i_b)) ? M_SHORT : M_RUN;
            r_n  <= 4'd8;
          end
        end
        M_SHORT: r_st <= M_IDLE;
        M_RUN: begin
          r_n <= r_n - 4'd1;
          if (r_n == 4'd1) r_st <= M_IDLE;
        end
        default: r_st <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (r_st)
      M_IDLE: begin
        if (i_start) begin
          r_mcand  <= PROD_W'(i_a);
          r_mplier <= i_b;
          r_p      <= '0;
        end
      end
      M_RUN: begin
        if (r_mplier[0]) r_p <= r_p + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      default: ;
    endcase
  end

  assign o_ready = (r_st == M_IDLE);
  assign o_r     = r_p;

endmodule

// File: rtl/mult_dot_seq.sv
// Dot-product sequencer: feeds operand pairs one at a time to an external
// sequential multiplier and accumulates the products into a held result.
module mult_dot_seq
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  mult_dot_seq_if.slave bus
);

  seq_state_t        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_last;
  logic              r_mult_start;
  logic              r_out_valid;
  logic [OPND_W-1:0] r_mult_a;
  logic [OPND_W-1:0] r_mult_b;

  logic [ACC_W:0]    w_sum;
  logic              w_cnt_sat;
  logic              w_in_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Carry out of the widened add is the overflow of this term.
  assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(bus.mult_r);
  assign w_cnt_sat  = &r_count;
  // Held low while reset is asserted even though the multiplier reports idle.
  assign w_in_ready = rst & (r_state == IDLE) & bus.mult_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_last       <= 1'b0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_mult_start <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_mult_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_mult_a     <= bus.in_a;
            r_mult_b     <= bus.in_b;
            r_last       <= bus.in_last;
            r_mult_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE:  r_state <= SETTLE;
        // Multiplier ready is stale for one cycle after start.
        SETTLE: r_state <= WAIT;
        WAIT: begin
          if (bus.mult_ready) r_state <= ACCUM;
        end
        ACCUM: begin
          r_acc   <= w_sum[ACC_W-1:0];
          r_ovf   <= r_ovf | w_sum[ACC_W] | w_cnt_sat;
          r_count <= sat_inc(r_count);
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.mult_start = r_mult_start;
  assign bus.mult_a     = r_mult_a;
  assign bus.mult_b     = r_mult_b;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sum    = r_acc;
  assign bus.out_count  = r_count;
  assign bus.out_ovf    = r_ovf;

endmodule

// File: tb/tb_mult_dot_seq.sv
// Bench for mult_dot_seq: two sequencers (24-bit and 17-bit accumulators) share one
// operand stream, each driving its own asmd_mult, checked against a sum-of-products model.
module tb_mult_dot_seq;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic w_mrst;

  int checks     = 0;
  int errors     = 0;
  int starts     = 0;
  int bad_starts = 0;
  int va[300];
  int vb[300];

  always #5 clk = ~clk;
  assign w_mrst = ~rst;

  mult_dot_seq_if #(.ACC_W(24), .CNT_W(8)) ifa ();
  mult_dot_seq_if #(.ACC_W(17), .CNT_W(8)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_a      = ifa.in_a;
  assign ifb.in_b      = ifa.in_b;
  assign ifb.in_last   = ifa.in_last;
  assign ifb.out_ready = ifa.out_ready;

  mult_dot_seq #(.ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mult_dot_seq #(.ACC_W(17), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  asmd_mult mul_a (.clk(clk), .rst(w_mrst), .i_start(ifa.mult_start), .i_a(ifa.mult_a),
                   .i_b(ifa.mult_b), .o_ready(ifa.mult_ready), .o_r(ifa.mult_r));
  asmd_mult mul_b (.clk(clk), .rst(w_mrst), .i_start(ifb.mult_start), .i_a(ifb.mult_a),
                   .i_b(ifb.mult_b), .o_ready(ifb.mult_ready), .o_r(ifb.mult_r));

  always @(negedge clk) begin
    if (rst && ifa.mult_start) begin
      starts++;
      if (!ifa.mult_ready) bad_starts++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input string tag, input int a, input int b, input bit last);
    int t = 0;
    ifa.in_valid = 1'b1;
    ifa.in_a     = 8'(a);
    ifa.in_b     = 8'(b);
    ifa.in_last  = last;
    while (!ifa.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic finish_vec(input string tag, input int n, input int bp);
    longint tot = 0;
    longint lim24 = longint'(1) << 24;
    longint lim17 = longint'(1) << 17;
    int t = 0;
    int cnt;
    for (int i = 0; i < n; i++) tot += longint'(va[i]) * longint'(vb[i]);
    cnt = (n > 255) ? 255 : n;
    while (!ifa.out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid_a"}, 64'(ifa.out_valid), 64'd1);
    chk({tag, "_valid_b"}, 64'(ifb.out_valid), 64'd1);
    for (int k = 0; k <= bp; k++) begin
      chk({tag, "_hold_valid"}, 64'(ifa.out_valid), 64'd1);
      chk({tag, "_sum24"}, 64'(ifa.out_sum), 64'(tot % lim24));
      chk({tag, "_cnt24"}, 64'(ifa.out_count), 64'(cnt));
      chk({tag, "_ovf24"}, 64'(ifa.out_ovf), 64'((tot >= lim24) || (n > 255)));
      chk({tag, "_sum17"}, 64'(ifb.out_sum), 64'(tot % lim17));
      chk({tag, "_cnt17"}, 64'(ifb.out_count), 64'(cnt));
      chk({tag, "_ovf17"}, 64'(ifb.out_ovf), 64'((tot >= lim17) || (n > 255)));
      chk({tag, "_in_ready_done"}, 64'(ifa.in_ready), 64'd0);
      if (k < bp) @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(ifa.out_valid), 64'd0);
    chk({tag, "_starts"}, 64'(starts), 64'(n));
    chk({tag, "_bad_starts"}, 64'(bad_starts), 64'd0);
  endtask

  task automatic run_vec(input string tag, input int n, input int bp);
    starts = 0;
    for (int i = 0; i < n; i++) send_pair(tag, va[i], vb[i], (i == n - 1));
    finish_vec(tag, n, bp);
  endtask

  initial begin
    ifa.in_valid  = 1'b0;
    ifa.in_a      = '0;
    ifa.in_b      = '0;
    ifa.in_last   = 1'b0;
    ifa.out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst_mult_start", 64'(ifa.mult_start), 64'd0);
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_out_sum", 64'(ifa.out_sum), 64'd0);
    chk("rst_out_count", 64'(ifa.out_count), 64'd0);
    chk("rst_out_ovf", 64'(ifa.out_ovf), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(ifa.in_ready), 64'd1);

    va[0] = 3; vb[0] = 4;
    run_vec("single", 1, 0);

    va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 5; vb[2] = 6;
    run_vec("vec3", 3, 0);

    va[0] = 0; vb[0] = 9; va[1] = 7; vb[1] = 0; va[2] = 2; vb[2] = 3;
    run_vec("zeros", 3, 1);

    for (int i = 0; i < 3; i++) begin va[i] = 255; vb[i] = 255; end
    run_vec("wrap17", 3, 0);

    va[0] = 10; vb[0] = 10;
    run_vec("backpr", 1, 5);

    starts = 0;
    send_pair("rstw", 5, 7, 1'b0);
    send_pair("rstw", 9, 9, 1'b0);
    repeat (2) @(negedge clk);
    chk("rstw_pre_sum", 64'(ifa.out_sum), 64'd35);
    rst = 1'b0;
    #1;
    chk("rstw_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rstw_mult_start", 64'(ifa.mult_start), 64'd0);
    chk("rstw_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rstw_out_sum", 64'(ifa.out_sum), 64'd0);
    chk("rstw_out_count", 64'(ifa.out_count), 64'd0);
    chk("rstw_out_ovf", 64'(ifa.out_ovf), 64'd0);
    chk("rstw_mult_a", 64'(ifa.mult_a), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    va[0] = 2; vb[0] = 2;
    run_vec("post_rst", 1, 0);

    for (int v = 0; v < 8; v++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        va[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
        vb[i] = int'($urandom_range(0, 255));
      end
      run_vec("rand", n, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 260; i++) begin va[i] = 255; vb[i] = 255; end
    run_vec("sat260", 260, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_dot_seq.md
Name: mult_dot_seq

Overview:
- Upstream sequencer for the 8x8 sequential multiplier (asmd_mult).
- Accepts a stream of operand pairs over valid/ready, framed by in_last.
- Issues one multiply per pair, waits for the product, and accumulates the products.
- Presents the dot-product sum, term count and overflow flag on a held output handshake.

Parameters:
- ACC_W, 24, accumulator/result width (min 16).
- CNT_W, 8, term counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_last  in  1  pair is final term of vector
- mult_start  out  1  start pulse to multiplier
- mult_a  out  8  multiplier operand A (registered)
- mult_b  out  8  multiplier operand B (registered)
- mult_ready  in  1  multiplier idle / result valid
- mult_r  in  16  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  accumulated sum
- out_count  out  CNT_W  number of terms accumulated
- out_ovf  out  1  sticky accumulator overflow

Behaviour:
- Reset (rst=0, async): state IDLE; acc, count, ovf, mult_a, mult_b, last_reg cleared. Outputs: in_ready=0, mult_start=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. All effects are immediate; an in-flight multiply is abandoned. The multiplier is reset by the same net.
- States: IDLE, ISSUE, SETTLE, WAIT, ACCUM, DONE.
- IDLE:
  - in_ready = mult_ready.
  - On in_valid & in_ready: latch in_a/in_b into mult_a/mult_b and in_last into last_reg, then go to ISSUE.
- ISSUE:
  - mult_start=1 for exactly one cycle.
  - mult_ready is guaranteed 1 here, so the multiplier samples start. Go to SETTLE.
- SETTLE:
  - One-cycle blind wait; mult_ready is ignored because the multiplier drops ready the cycle after start.
  - Go to WAIT.
- WAIT:
  - Hold until mult_ready=1, then go to ACCUM.
  - A zero operand (multiplier short path) returns ready on the first WAIT cycle; this is legal.
- ACCUM:
  - acc <= acc + zero-extended mult_r, modulo 2^ACC_W.
  - ovf <= ovf | carry-out.
  - count <= count+1, saturating at 2^CNT_W-1; saturation also sets ovf.
  - If last_reg, go to DONE; else go to IDLE.
- DONE:
  - out_valid=1.
  - out_sum, out_count and out_ovf are driven from acc, count and ovf and held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: clear acc, count and ovf; go to IDLE. out_valid drops the next cycle.
  - in_ready=0 throughout DONE (backpressure).
- Outside DONE: out_valid=0. out_sum/out_count/out_ovf show live acc/count/ovf and are don't-care to consumers.
- Per-term latency, from accept to ACCUM inclusive: 4 cycles + multiplier busy time.
- Result latency: the last ACCUM is followed by out_valid on the next cycle.
- in_last=1 on a single-pair vector is legal and gives count=1.
- in_valid with mult_ready=0 in IDLE: the pair is not accepted (in_ready=0). The source must hold its data.
- mult_start never asserts outside ISSUE; never more than one multiply is outstanding.
- Vectors never interleave; a new vector starts only after DONE completes.

Decomposition:
- Shared package mult_pkg holds:
  - the seq_state_t enum (IDLE, ISSUE, SETTLE, WAIT, ACCUM, DONE);
  - OPND_W=8 and PROD_W=16 constants;
  - default ACC_W/CNT_W localparams.
- No sub-module in the RTL. The testbench instantiates mult_dot_seq alongside asmd_mult (with reset inverted for it) as the multiply engine.

Test Plan:
- Single pair (3,4,last=1) -> one mult_start pulse; out_valid with out_sum=12, out_count=1, out_ovf=0.
- Vector (1,2),(3,4),(5,6,last) -> out_sum=44, out_count=3; exactly 3 mult_start pulses, none while mult_ready=0.
- Zero operands (0,9),(7,0),(2,3,last) -> out_sum=6, out_count=3; short-path ready return handled, no hang.
- ACC_W=17, three pairs (255,255) -> out_sum=64003 (195075 mod 131072), out_ovf=1.
- Result (10,10,last), out_ready held 0 for 5 cycles -> out_valid and out_sum=100 stable for all 5; in_ready=0; after accept, the next vector starts from acc=0.
- rst=0 pulsed during WAIT of a 3-term vector -> all outputs 0 immediately; the next vector (2,2,last) gives out_sum=4, out_count=1.
